// File: rtl/elevator_call_scheduler_pkg.sv
// Shared state encodings, floor/direction constants and sensor helpers for the elevator scheduler.
// Pure definitions: no latency, no flow control.
package elevator_call_scheduler_pkg;

    localparam int N_FLOORS = 3;
    localparam int FLOOR_W  = 2;
    localparam int HOLD_W   = 4;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_MOVE       = 2'd1;
    localparam logic [1:0] ST_DOOR_OPEN  = 2'd2;
    localparam logic [1:0] ST_DOOR_CLOSE = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef logic [N_FLOORS-1:0] calls_t;
    typedef logic [FLOOR_W-1:0]  floor_t;

    typedef struct packed {
        logic   vld;
        floor_t idx;
    } sensor_dec_t;

    // Only a clean one-hot reading counts as being at a floor.
    function automatic sensor_dec_t decode_sensor(input calls_t s);
        sensor_dec_t d;
        d.vld = 1'b1;
        d.idx = '0;
        case (s)
            3'b001:  d.idx = 2'd0;
            3'b010:  d.idx = 2'd1;
            3'b100:  d.idx = 2'd2;
            default: d.vld = 1'b0;
        endcase
        return d;
    endfunction

    function automatic calls_t floor_mask(input floor_t f);
        calls_t m;
        case (f)
            2'd0:    m = 3'b001;
            2'd1:    m = 3'b010;
            2'd2:    m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Button, sensor and actuator bundle between the car hardware and the call scheduler.
// Wires only: no latency, no backpressure (all inputs are level-sampled every cycle).
interface elevator_call_scheduler_if;
    import elevator_call_scheduler_pkg::*;

    calls_t I;
    calls_t E;
    calls_t S;
    logic   R;
    logic   M;
    logic   D;
    logic   P;
    calls_t Pend;
    floor_t Floor;

    modport master (
        output I, E, S, R,
        input  M, D, P, Pend, Floor
    );

    modport slave (
        input  I, E, S, R,
        output M, D, P, Pend, Floor
    );

endinterface

// File: rtl/elevator_call_scheduler_call_ahead.sv
// Flags pending calls ahead of / behind the car relative to its floor and direction.
// Purely combinational, zero latency, no backpressure.
module call_ahead_logic
    import elevator_call_scheduler_pkg::*;
(
    input  calls_t pend,
    input  floor_t floor,
    input  logic   dir,
    output logic   ahead,
    output logic   behind
);

    calls_t above_mask;
    calls_t below_mask;
    logic   above;
    logic   below;

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        case (floor)
            2'd0: above_mask = 3'b110;
            2'd1: begin
                above_mask = 3'b100;
                below_mask = 3'b001;
            end
            2'd2: below_mask = 3'b011;
            default: ;
        endcase
    end

    assign above  = |(pend & above_mask);
    assign below  = |(pend & below_mask);
    assign ahead  = (dir == DIR_UP) ? above : below;
    assign behind = (dir == DIR_UP) ? below : above;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective call scheduler for a 3-floor car: latches calls, tracks floor, sequences motor and door.
// Outputs registered one cycle after each decision; no backpressure, buttons/sensors sampled every cycle.
module elevator_call_scheduler
    import elevator_call_scheduler_pkg::*;
#(
    parameter int DOOR_HOLD = 4
) (
    input  logic Clk,
    input  logic Reset,
    elevator_call_scheduler_if.slave car
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DOOR_HOLD - 1);

    logic [1:0]        st_q;
    logic [1:0]        st_nxt;
    floor_t            floor_q;
    logic              dir_q;
    logic              dir_nxt;
    calls_t            pend_q;
    calls_t            pend_nxt;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_nxt;
    logic              m_q;
    logic              p_q;

    calls_t      req;
    calls_t      pend_set;
    calls_t      here;
    calls_t      clr;
    sensor_dec_t sdec;
    floor_t      floor_eff;
    logic        call_here;
    logic        pend_here;
    logic        at_limit;
    logic        ahead;
    logic        behind;

    // Decisions see this cycle's button presses and sensor reading, not last cycle's.
    assign req       = car.I | car.E;
    assign pend_set  = pend_q | req;
    assign sdec      = decode_sensor(car.S);
    assign floor_eff = sdec.vld ? sdec.idx : floor_q;
    assign here      = floor_mask(floor_eff);
    assign call_here = |(req & here);
    assign pend_here = |(pend_set & here);
    assign at_limit  = ((floor_eff == 2'd2) && (dir_q == DIR_UP)) ||
                       ((floor_eff == 2'd0) && (dir_q == DIR_DOWN));

    call_ahead_logic u_call_ahead (
        .pend   (pend_set),
        .floor  (floor_eff),
        .dir    (dir_q),
        .ahead  (ahead),
        .behind (behind)
    );

    always_comb begin
        st_nxt  = st_q;
        dir_nxt = dir_q;
        cnt_nxt = cnt_q;
        case (st_q)
            ST_IDLE: begin
                if (pend_here) begin
                    st_nxt  = ST_DOOR_OPEN;
                    cnt_nxt = HOLD_LOAD;
                end else if (ahead) begin
                    st_nxt = ST_MOVE;
                end else if (behind) begin
                    st_nxt  = ST_MOVE;
                    dir_nxt = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                end
            end
            ST_MOVE: begin
                if (sdec.vld) begin
                    if (pend_here) begin
                        st_nxt  = ST_DOOR_OPEN;
                        cnt_nxt = HOLD_LOAD;
                    end else if (!ahead) begin
                        st_nxt = ST_IDLE;
                    end
                end else if (at_limit) begin
                    // Sensor lost beyond an end floor: never keep driving outward.
                    st_nxt = ST_IDLE;
                end
            end
            ST_DOOR_OPEN: begin
                if (call_here) begin
                    cnt_nxt = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    st_nxt = ST_DOOR_CLOSE;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_DOOR_CLOSE: begin
                if (call_here) begin
                    st_nxt  = ST_DOOR_OPEN;
                    cnt_nxt = HOLD_LOAD;
                end else if (car.R) begin
                    st_nxt = ST_IDLE;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    // A call at the floor whose door is (or is about to be) open is served on the spot.
    assign clr      = ((st_nxt == ST_DOOR_OPEN) || (st_q == ST_DOOR_OPEN)) ? here : '0;
    assign pend_nxt = pend_set & ~clr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            st_q    <= ST_IDLE;
            floor_q <= '0;
            dir_q   <= DIR_UP;
            pend_q  <= '0;
            cnt_q   <= '0;
            m_q     <= 1'b0;
            p_q     <= 1'b0;
        end else begin
            st_q    <= st_nxt;
            floor_q <= floor_eff;
            dir_q   <= dir_nxt;
            pend_q  <= pend_nxt;
            cnt_q   <= cnt_nxt;
            m_q     <= (st_nxt == ST_MOVE);
            p_q     <= (st_nxt == ST_DOOR_OPEN);
        end
    end

    assign car.M     = m_q;
    assign car.D     = dir_q;
    assign car.P     = p_q;
    assign car.Pend  = pend_q;
    assign car.Floor = floor_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed walk through the call-scheduling scenarios followed by a randomized ride on a simple car plant.
// Every cycle the DUT is compared with a rule-level reference model of the controller.
module tb_elevator_call_scheduler;

    localparam int DOOR_HOLD = 4;

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    elevator_call_scheduler_if bus ();

    elevator_call_scheduler #(.DOOR_HOLD(DOOR_HOLD)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .car   (bus)
    );

    always #5 Clk = ~Clk;

    // Reference model: calls as a bit set, door as "cycles of opening left", motion as a flag.
    logic [2:0] m_calls;
    int         m_floor;
    bit         m_up;
    bit         m_moving;
    int         m_open_left;
    bit         m_closing;

    function automatic bit calls_toward(input logic [2:0] c, input int f, input bit up);
        int k;
        bit found;
        found = 1'b0;
        k = up ? f + 1 : f - 1;
        while (k >= 0 && k <= 2) begin
            if (c[k]) found = 1'b1;
            k = up ? k + 1 : k - 1;
        end
        return found;
    endfunction

    task automatic model_step(input logic [2:0] i, input logic [2:0] e, input logic [2:0] s,
                              input logic r, input logic rst);
        logic [2:0] req;
        logic [2:0] calls;
        int f, fs;
        bit served;
        if (rst) begin
            m_calls = 3'b000; m_floor = 0; m_up = 1'b1;
            m_moving = 1'b0; m_open_left = 0; m_closing = 1'b0;
            return;
        end
        req = i | e;
        fs  = -1;
        if (s == 3'b001) fs = 0;
        else if (s == 3'b010) fs = 1;
        else if (s == 3'b100) fs = 2;
        f      = (fs >= 0) ? fs : m_floor;
        calls  = m_calls | req;
        served = 1'b0;
        if (m_open_left > 0) begin
            served = 1'b1;
            if (req[f]) m_open_left = DOOR_HOLD;
            else if (m_open_left == 1) begin m_open_left = 0; m_closing = 1'b1; end
            else m_open_left = m_open_left - 1;
        end else if (m_closing) begin
            if (req[f]) begin m_closing = 1'b0; m_open_left = DOOR_HOLD; served = 1'b1; end
            else if (r) m_closing = 1'b0;
        end else if (m_moving) begin
            if (fs >= 0) begin
                if (calls[fs]) begin m_moving = 1'b0; m_open_left = DOOR_HOLD; served = 1'b1; end
                else if (!calls_toward(calls, fs, m_up)) m_moving = 1'b0;
            end else if ((f == 2 && m_up) || (f == 0 && !m_up)) begin
                m_moving = 1'b0;
            end
        end else if (calls != 3'b000) begin
            if (calls[f]) begin m_open_left = DOOR_HOLD; served = 1'b1; end
            else begin
                if (!calls_toward(calls, f, m_up)) m_up = !m_up;
                m_moving = 1'b1;
            end
        end
        if (served) calls[f] = 1'b0;
        m_calls = calls;
        m_floor = f;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".M"},     8'(bus.M),     8'(m_moving));
        chk({tag, ".D"},     8'(bus.D),     8'(m_up));
        chk({tag, ".P"},     8'(bus.P),     8'(m_open_left > 0));
        chk({tag, ".Pend"},  8'(bus.Pend),  8'(m_calls));
        chk({tag, ".Floor"}, 8'(bus.Floor), 8'(m_floor));
        chk({tag, ".MP"},    8'(bus.M & bus.P), 8'd0);
    endtask

    task automatic tick(input logic [2:0] i, input logic [2:0] e, input logic [2:0] s,
                        input logic r, input logic rst, input string tag);
        bus.I = i; bus.E = e; bus.S = s; bus.R = r; Reset = rst;
        @(posedge Clk);
        model_step(i, e, s, r, rst);
        #1;
        check_all(tag);
    endtask

    task automatic finish_door(input logic [2:0] s);
        for (int k = 0; k < DOOR_HOLD; k++) tick(3'b000, 3'b000, s, 1'b0, 1'b0, "door");
        tick(3'b000, 3'b000, s, 1'b1, 1'b0, "door_r");
    endtask

    int pos;
    int travel;
    int p_cnt;

    initial begin
        bus.I = '0; bus.E = '0; bus.S = 3'b001; bus.R = 1'b0; Reset = 1'b1;

        // Reset state
        tick(3'b000, 3'b000, 3'b001, 1'b0, 1'b1, "rst");
        tick(3'b000, 3'b000, 3'b001, 1'b0, 1'b1, "rst");
        chk("rst_M", 8'(bus.M), 8'd0);
        chk("rst_D", 8'(bus.D), 8'd1);
        chk("rst_P", 8'(bus.P), 8'd0);
        chk("rst_Pend", 8'(bus.Pend), 8'd0);
        chk("rst_Floor", 8'(bus.Floor), 8'd0);

        // Hall call at the current floor: door opens for exactly DOOR_HOLD cycles
        p_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick(3'b000, (k == 0) ? 3'b001 : 3'b000, 3'b001, 1'b0, 1'b0, "t1");
            if (k == 0) chk("t1_pend_clear", 8'(bus.Pend), 8'd0);
            if (bus.P) p_cnt++;
        end
        chk("t1_p_cycles", 8'(p_cnt), 8'(DOOR_HOLD));
        tick(3'b000, 3'b000, 3'b001, 1'b1, 1'b0, "t1_r");
        chk("t1_idle_M", 8'(bus.M), 8'd0);
        chk("t1_idle_P", 8'(bus.P), 8'd0);

        // Cabin call to floor 2: pass floor 1 without stopping
        tick(3'b100, 3'b000, 3'b001, 1'b0, 1'b0, "t2");
        chk("t2_M", 8'(bus.M), 8'd1);
        chk("t2_D", 8'(bus.D), 8'd1);
        chk("t2_Pend", 8'(bus.Pend), 8'b100);
        tick(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "t2");
        tick(3'b000, 3'b000, 3'b010, 1'b0, 1'b0, "t2");
        chk("t2_pass_f1", 8'(bus.M), 8'd1);
        tick(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "t2");
        tick(3'b000, 3'b000, 3'b100, 1'b0, 1'b0, "t2");
        chk("t2_stop_M", 8'(bus.M), 8'd0);
        chk("t2_stop_P", 8'(bus.P), 8'd1);
        chk("t2_stop_Pend", 8'(bus.Pend), 8'd0);
        chk("t2_stop_Floor", 8'(bus.Floor), 8'd2);
        finish_door(3'b100);

        // Multi-hot sensor glitch leaves the floor alone
        tick(3'b000, 3'b000, 3'b011, 1'b0, 1'b0, "glitch");
        chk("glitch_Floor", 8'(bus.Floor), 8'd2);

        // At top floor going up, a call below flips direction in IDLE
        tick(3'b001, 3'b000, 3'b100, 1'b0, 1'b0, "t4");
        chk("t4_D", 8'(bus.D), 8'd0);
        chk("t4_M", 8'(bus.M), 8'd1);
        tick(3'b000, 3'b000, 3'b100, 1'b0, 1'b0, "t4");
        tick(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "t4");
        tick(3'b000, 3'b000, 3'b010, 1'b0, 1'b0, "t4");
        tick(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "t4");
        tick(3'b000, 3'b000, 3'b001, 1'b0, 1'b0, "t4");
        chk("t4_Floor", 8'(bus.Floor), 8'd0);
        chk("t4_M_stop", 8'(bus.M), 8'd0);
        finish_door(3'b001);

        // Hall call at floor 1 caught en route to floor 2
        tick(3'b100, 3'b000, 3'b001, 1'b0, 1'b0, "t3");
        tick(3'b000, 3'b010, 3'b000, 1'b0, 1'b0, "t3");
        tick(3'b000, 3'b000, 3'b010, 1'b0, 1'b0, "t3");
        chk("t3_Floor", 8'(bus.Floor), 8'd1);
        chk("t3_P", 8'(bus.P), 8'd1);
        chk("t3_Pend", 8'(bus.Pend), 8'b100);
        finish_door(3'b010);
        tick(3'b000, 3'b000, 3'b010, 1'b0, 1'b0, "t3");
        chk("t3_resume_M", 8'(bus.M), 8'd1);
        chk("t3_resume_D", 8'(bus.D), 8'd1);
        tick(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "t3");
        tick(3'b000, 3'b000, 3'b100, 1'b0, 1'b0, "t3");
        finish_door(3'b100);

        // Reopen from DOOR_CLOSE at floor 1
        tick(3'b010, 3'b000, 3'b100, 1'b0, 1'b0, "t5");
        tick(3'b000, 3'b000, 3'b100, 1'b0, 1'b0, "t5");
        tick(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "t5");
        tick(3'b000, 3'b000, 3'b010, 1'b0, 1'b0, "t5");
        for (int k = 0; k < DOOR_HOLD; k++) tick(3'b000, 3'b000, 3'b010, 1'b0, 1'b0, "t5");
        chk("t5_closing_P", 8'(bus.P), 8'd0);
        p_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick(3'b000, (k == 0) ? 3'b010 : 3'b000, 3'b010, 1'b0, 1'b0, "t5");
            if (k == 0) chk("t5_reopen_Pend", 8'(bus.Pend), 8'd0);
            if (bus.P) p_cnt++;
        end
        chk("t5_reopen_cycles", 8'(p_cnt), 8'(DOOR_HOLD));
        tick(3'b000, 3'b010, 3'b010, 1'b1, 1'b0, "t5");
        chk("t5_reopen_wins", 8'(bus.P), 8'd1);
        finish_door(3'b010);

        // Reset in the middle of a move
        tick(3'b100, 3'b000, 3'b010, 1'b0, 1'b0, "t6");
        tick(3'b000, 3'b010, 3'b000, 1'b0, 1'b0, "t6");
        chk("t6_Pend", 8'(bus.Pend), 8'b110);
        chk("t6_M", 8'(bus.M), 8'd1);
        tick(3'b000, 3'b000, 3'b000, 1'b0, 1'b1, "t6_rst");
        chk("t6_rst_M", 8'(bus.M), 8'd0);
        chk("t6_rst_P", 8'(bus.P), 8'd0);
        chk("t6_rst_Pend", 8'(bus.Pend), 8'd0);
        chk("t6_rst_D", 8'(bus.D), 8'd1);
        for (int k = 0; k < 3; k++) begin
            tick(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "t6_still");
            chk("t6_no_motion", 8'(bus.M), 8'd0);
        end

        // Randomized ride: car plant moves half a floor every two motor-on cycles
        tick(3'b000, 3'b000, 3'b001, 1'b0, 1'b1, "rand_rst");
        pos = 0;
        travel = 0;
        for (int n = 0; n < 2000; n++) begin
            logic [2:0] ri, re, rs;
            logic rr, rrst;
            ri   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            re   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            rr   = ($urandom_range(0, 2) == 0);
            rrst = ($urandom_range(0, 399) == 0);
            rs   = (pos % 2 == 0) ? 3'(1 << (pos / 2)) : 3'b000;
            if ($urandom_range(0, 39) == 0) rs = 3'b101;
            tick(ri, re, rs, rr, rrst, "rand");
            if (m_moving) begin
                travel++;
                if (travel >= 2) begin
                    travel = 0;
                    pos = pos + (m_up ? 1 : -1);
                    if (pos < 0) pos = 0;
                    if (pos > 4) pos = 4;
                end
            end else begin
                travel = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Call-registering and sequencing controller for the 3-floor elevator car.
- Latches cabin (I) and hall (E) button presses into a pending-call register.
- Tracks the current floor from the floor sensors (S) and drives the motor, direction and door commands.
- Serves calls collectively: keeps its direction while calls remain ahead, then reverses.
- Sits between the button/sensor inputs and the car's motor and door actuators.

Parameters:
DOOR_HOLD, 4, cycles the door-open command stays high (range 1..15).

Ports:
Clk  input  1  system clock, all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
I  input  3  cabin call buttons; bit k = floor k; level-sensitive, sampled every cycle.
E  input  3  hall call buttons; bit k = floor k; level-sensitive.
S  input  3  floor sensors; one-hot while the car is at a floor, 000 between floors.
R  input  1  door-closed confirmation from the door mechanism.
M  output  1  motor enable.
D  output  1  direction; 1 = up, 0 = down.
P  output  1  door-open command.
Pend  output  3  pending-call register, used for the button lamps.
Floor  output  2  current floor, 0..2.

Behaviour:
Reset (Reset=1 at a rising edge):
- State IDLE; M=0, D=1, P=0, Pend=000, Floor=0, hold counter=0.
- Reset mid-motion stops the motor on the next edge.

Floor tracking:
- Whenever S is one-hot, Floor <= index of the set bit.
- S=000 or multi-hot: Floor holds.

Call register:
- Each cycle, Pend <= (Pend | I | E) & ~clr.
- clr = one-hot of Floor in any cycle where the next state is DOOR_OPEN or the state is DOOR_OPEN.
- When set and clear hit the same bit, clear wins.
- Calls on other floors are always set.

States (registered outputs, 1-cycle latency from decision to M/P):
- IDLE (M=0, P=0):
  - Pend=000: stay.
  - Pend[Floor]=1: go to DOOR_OPEN.
  - Any call ahead in D: go to MOVE.
  - Only calls behind: toggle D, go to MOVE.
- MOVE (M=1, P=0):
  - When S is one-hot with bit f and Pend[f]=1 (after the same-cycle I/E merge): go to DOOR_OPEN; M=0 from the next cycle.
  - When S is one-hot with bit f, Pend[f]=0, and no call ahead: go to IDLE.
  - Limits: at Floor=2 with D=1, or Floor=0 with D=0, always leave MOVE (stop or IDLE); M is never 1 past an end floor.
- DOOR_OPEN (M=0, P=1):
  - Hold counter loads DOOR_HOLD-1 on entry and decrements each cycle.
  - A new call for Floor while in this state reloads the counter (door re-hold).
  - At 0: go to DOOR_CLOSE.
- DOOR_CLOSE (M=0, P=0):
  - R=1: go to IDLE.
  - I[Floor] or E[Floor]=1 before R: go back to DOOR_OPEN (reopen); the call is cleared.
  - If both in the same cycle, reopen has priority.

Invariants:
- M and P are never 1 together.
- D changes only in IDLE.

Decomposition:
- Shared include elevator_defs.vh holds: state encodings ST_IDLE=2'd0, ST_MOVE=2'd1, ST_DOOR_OPEN=2'd2, ST_DOOR_CLOSE=2'd3; DIR_UP=1'b1, DIR_DOWN=1'b0; N_FLOORS=3.
- One natural sub-module, call_ahead_logic: combinational; from Pend, Floor and D it produces ahead and behind flags. It is reused by both the IDLE and MOVE decisions.

Test Plan:
- Reset, then E=001 for 1 cycle at Floor 0 (S=001):
  - State goes to DOOR_OPEN next cycle.
  - P=1 for exactly 4 cycles; Pend stays 000.
  - With R=1, returns to IDLE with M=0.
- From Floor 0, idle, pulse I=100:
  - M=1, D=1; Pend=100.
  - S sequence 000, 010, 000, 100: car passes floor 1 without stopping.
  - M=0 one cycle after S=100; P=1; Pend=000; Floor=2.
- Car moving up from 0 with Pend=100; press E=010 while S=000:
  - Car stops at S=010 (Floor=1, P=1), Pend=100.
  - After door close with R=1, continues up: M=1, D=1.
- At Floor 2 idle with D=1, press I=001:
  - D toggles to 0 in IDLE and M=1.
  - Stops when S=001; Floor=0.
- In DOOR_CLOSE at Floor 1 with R=0, pulse E=010:
  - P returns to 1 the next cycle for 4 cycles; Pend[1] stays 0.
  - Separately, R=1 and E=010 in the same cycle: reopen wins.
- Assert Reset for 1 cycle during MOVE with Pend=110:
  - Next cycle M=0, P=0, Pend=000, D=1, state IDLE.
  - No motion until a new call arrives.
